// File: rtl/dtw_result_filter.sv
`default_nettype none
// ============================================================================
//  Module   : dtw_result_filter
//  Purpose  : Pops 3-word DTW result records (qid, pos, cost) from an FWFT
//             FIFO, compares the cost against a threshold, and forwards a
//             tagged 3-word record on AXI-Stream. Non-matching records can
//             be dropped. Keeps result/match/drop statistics.
//  Revision : 1.0 - initial release
// ============================================================================
module dtw_result_filter #(
   parameter int WIDTH      = 16,
   parameter int AXIS_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [WIDTH-1:0]      threshold,
   input  logic                  drop_nonmatch,
   input  logic                  clear_stats,
   output logic                  res_fifo_rden,
   input  logic                  res_fifo_empty,
   input  logic [31:0]           res_fifo_data,
   output logic [AXIS_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  busy,
   output logic [31:0]           stat_nresult,
   output logic [31:0]           stat_nmatch,
   output logic [31:0]           stat_ndrop,
   output logic [2:0]            dbg_state
);

   localparam logic [2:0] C_IDLE    = 3'd0;
   localparam logic [2:0] C_RD_QID  = 3'd1;
   localparam logic [2:0] C_RD_POS  = 3'd2;
   localparam logic [2:0] C_RD_COST = 3'd3;
   localparam logic [2:0] C_DECIDE  = 3'd4;
   localparam logic [2:0] C_EMIT    = 3'd5;

   logic [2:0]            r_state;
   logic [2:0]            w_next;
   logic [31:0]           r_qid;
   logic [31:0]           r_pos;
   logic [WIDTH-1:0]      r_cost;
   logic                  r_match;
   logic [1:0]            r_widx;
   logic [AXIS_WIDTH-1:0] r_tdata;
   logic                  r_tvalid;
   logic                  r_tlast;
   logic [31:0]           r_nresult;
   logic [31:0]           r_nmatch;
   logic [31:0]           r_ndrop;

   logic                  w_match;
   logic                  w_drop;
   logic                  w_hs;
   logic [AXIS_WIDTH-1:0] w_word2;

   assign w_match = (r_cost <= threshold);
   assign w_drop  = !w_match && drop_nonmatch;
   assign w_hs    = r_tvalid && m_axis_tready;
   // Final word carries the match flag in the MSB and the cost in the LSBs.
   assign w_word2 = {r_match, {(AXIS_WIDTH-1-WIDTH){1'b0}}, r_cost};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= C_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic; enable only gates the start of a new record
   always_comb begin
      w_next = r_state;
      case (r_state)
         C_IDLE:    if (enable && !res_fifo_empty) w_next = C_RD_QID;
         C_RD_QID:  if (!res_fifo_empty) w_next = C_RD_POS;
         C_RD_POS:  if (!res_fifo_empty) w_next = C_RD_COST;
         C_RD_COST: if (!res_fifo_empty) w_next = C_DECIDE;
         C_DECIDE:  w_next = w_drop ? C_IDLE : C_EMIT;
         C_EMIT:    if (w_hs && (r_widx == 2'd2)) w_next = C_IDLE;
         default:   w_next = C_IDLE;
      endcase
   end

   // Output decode: FIFO pop only in read states with data present
   always_comb begin
      res_fifo_rden = 1'b0;
      busy          = (r_state != C_IDLE);
      if ((r_state == C_RD_QID) || (r_state == C_RD_POS) || (r_state == C_RD_COST))
         res_fifo_rden = !res_fifo_empty;
   end

   // Capture the record words on the same edge as the pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_qid  <= '0;
         r_pos  <= '0;
         r_cost <= '0;
      end else if (res_fifo_rden) begin
         if (r_state == C_RD_QID) r_qid  <= res_fifo_data;
         if (r_state == C_RD_POS) r_pos  <= res_fifo_data;
         if (r_state == C_RD_COST) r_cost <= res_fifo_data[WIDTH-1:0];
      end
   end

   // AXI-Stream word sequencer; outputs only move on a handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_match  <= 1'b0;
         r_widx   <= 2'd0;
         r_tdata  <= '0;
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
      end else if ((r_state == C_DECIDE) && !w_drop) begin
         r_match  <= w_match;
         r_widx   <= 2'd0;
         r_tdata  <= AXIS_WIDTH'(r_qid);
         r_tvalid <= 1'b1;
         r_tlast  <= 1'b0;
      end else if ((r_state == C_EMIT) && w_hs) begin
         case (r_widx)
            2'd0: begin
               r_tdata <= AXIS_WIDTH'(r_pos);
               r_widx  <= 2'd1;
            end
            2'd1: begin
               r_tdata <= w_word2;
               r_tlast <= 1'b1;
               r_widx  <= 2'd2;
            end
            default: begin
               r_tvalid <= 1'b0;
               r_tlast  <= 1'b0;
               r_widx   <= 2'd0;
            end
         endcase
      end
   end

   // Statistics counters; a clear overrides a coincident increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_nresult <= '0;
         r_nmatch  <= '0;
         r_ndrop   <= '0;
      end else if (clear_stats) begin
         r_nresult <= '0;
         r_nmatch  <= '0;
         r_ndrop   <= '0;
      end else if (r_state == C_DECIDE) begin
         r_nresult <= r_nresult + 32'd1;
         if (w_match) r_nmatch <= r_nmatch + 32'd1;
         if (w_drop)  r_ndrop  <= r_ndrop + 32'd1;
      end
   end

   assign m_axis_tdata  = r_tdata;
   assign m_axis_tvalid = r_tvalid;
   assign m_axis_tlast  = r_tlast;
   assign stat_nresult  = r_nresult;
   assign stat_nmatch   = r_nmatch;
   assign stat_ndrop    = r_ndrop;
   assign dbg_state     = r_state;

endmodule
`default_nettype wire

// File: doc/dtw_result_filter.md
Name: dtw_result_filter

Overview:
- Sits directly downstream of the DTW core's sink FIFO.
- Pops the 3-word result records (query id, best position, min cost) that the core serialises into that FIFO.
- Classifies each query against a programmable cost threshold and forwards a tagged 3-word record on an AXI-Stream master toward the DMA. Non-matching records are optionally dropped.
- Keeps running statistics counters for the control/status register block.

Parameters:
- WIDTH, 16, cost width; min cost occupies result word 2 bits [WIDTH-1:0].
- AXIS_WIDTH, 32, AXI-Stream data width; FIFO data width is also 32.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  1 = process records; 0 = stop at the next record boundary
- threshold  in  WIDTH  match if min cost <= threshold (unsigned)
- drop_nonmatch  in  1  1 = discard non-matching records
- clear_stats  in  1  synchronous one-cycle clear of all statistics counters
- res_fifo_rden  out  1  result FIFO pop (combinational)
- res_fifo_empty  in  1  result FIFO empty
- res_fifo_data  in  32  result FIFO head word (first-word-fall-through)
- m_axis_tdata  out  AXIS_WIDTH  output record word
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last word of record
- busy  out  1  high when not in IDLE
- stat_nresult  out  32  records consumed
- stat_nmatch  out  32  records with match
- stat_ndrop  out  32  records discarded
- dbg_state  out  3  FSM state encoding

Behaviour:
- Reset (rst_n low, async):
  - FSM goes to IDLE.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0.
  - All statistics counters and capture registers = 0.
  - res_fifo_rden=0, since it is combinational and zero outside the read states.
- FIFO protocol (FWFT):
  - Data is valid whenever res_fifo_empty=0.
  - res_fifo_rden = (state in RD_QID/RD_POS/RD_COST) && !res_fifo_empty.
  - The word is captured on the same edge as the pop. No pop is ever issued while empty.
- FSM states and encoding: IDLE=0, RD_QID=1, RD_POS=2, RD_COST=3, DECIDE=4, EMIT=5.
  - IDLE:
    - enable && !empty -> RD_QID.
    - Otherwise stay in IDLE.
  - RD_QID / RD_POS / RD_COST:
    - Capture qid / pos / cost, respectively, when !empty, then advance to the next state.
    - Stall in place while empty; a stall has no length limit.
    - cost = data[WIDTH-1:0]; upper bits are ignored.
  - DECIDE (one cycle):
    - match = (cost <= threshold).
    - stat_nresult +1; stat_nmatch +1 if match.
    - If !match && drop_nonmatch: stat_ndrop +1, go to IDLE.
    - Otherwise load the output word index to 0 and go to EMIT.
  - EMIT: three words, each held stable until accepted.
    - Word 0 = qid.
    - Word 1 = pos.
    - Word 2 = {match, (AXIS_WIDTH-1-WIDTH) zeros, cost}.
    - tlast=1 only on word 2.
    - tvalid is registered: it rises the cycle after DECIDE.
    - The word index advances only on tvalid && tready.
    - After word 2 is accepted: tvalid=0, tlast=0, go to IDLE. The next record may start one cycle later.
    - tdata, tlast and tvalid must not change while tvalid && !tready (AXI rule).
- enable:
  - Sampled only in IDLE; a record already in progress always completes.
  - Deasserting enable mid-record therefore never truncates the output stream or desynchronises FIFO framing.
- threshold and drop_nonmatch: sampled in DECIDE only. Changing them mid-record affects only records whose DECIDE has not yet occurred.
- clear_stats:
  - Zeroes all three counters on the next edge.
  - If it coincides with a DECIDE increment, clear wins and the counter reads 0.
- Counters wrap modulo 2^32 with no saturation.
- Minimum throughput with no stalls: 3 read cycles + 1 DECIDE cycle + 3 emit cycles + 1 return to IDLE = 8 cycles per record. Dropped records take 5 cycles.

Test Plan:
- Match record: threshold=0x0100; FIFO holds {7, 1234, 0x0080}, tready=1 -> output words 7, 1234, 0x80000080; tlast on word 3 only; nresult=1, nmatch=1, ndrop=0; three pops total.
- Drop: drop_nonmatch=1, threshold=0x0010, FIFO {9, 55, 0x0011} -> no tvalid ever; nresult=1, ndrop=1, FIFO empty after 5 cycles. Same record with drop_nonmatch=0 -> words 9, 55, 0x00000011.
- Boundary equality and backpressure: cost == threshold=0xFFFF -> match bit set. tready toggled 1/0 every cycle -> data stable while stalled; exactly 3 handshakes.
- FIFO starvation: push qid, wait 20 cycles, push pos, wait, push cost -> no pop while empty; correct record output; dbg_state stalls at 2 then 3.
- enable dropped during RD_POS with two records queued -> first record completes fully; second is not popped until enable returns; clear_stats coinciding with DECIDE -> counters read 0.
- Async reset asserted during EMIT with tready=0 -> tvalid drops immediately (no clock edge needed); after release, the block restarts cleanly on the next queued record.
